// File: rtl/rx_frame_pkg.sv
// Shared encodings for the receive-frame controller: FSM states, command bytes
// and the error codes reported alongside frame_err.
package rx_frame_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CMD     = 3'd1;
  localparam logic [2:0] ST_LEN     = 3'd2;
  localparam logic [2:0] ST_PAYLOAD = 3'd3;
  localparam logic [2:0] ST_CSUM    = 3'd4;

  localparam logic [7:0] CMD_LOAD_A = 8'h01;
  localparam logic [7:0] CMD_LOAD_B = 8'h02;
  localparam logic [7:0] CMD_START  = 8'h03;

  localparam logic [2:0] ERR_TIMEOUT   = 3'd0;
  localparam logic [2:0] ERR_CMD       = 3'd1;
  localparam logic [2:0] ERR_LEN       = 3'd2;
  localparam logic [2:0] ERR_CSUM      = 3'd3;
  localparam logic [2:0] ERR_NOT_READY = 3'd4;

  function automatic logic is_load_cmd(input logic [7:0] cmd);
    return (cmd == CMD_LOAD_A) || (cmd == CMD_LOAD_B);
  endfunction

endpackage

// File: rtl/rx_timeout_cnt.sv
// Inter-byte watchdog: counts byte-less cycles inside a frame and flags expiry
// on the cycle whose edge would bring the count to TIMEOUT-1.
module rx_timeout_cnt #(
  parameter int TIMEOUT = 64,
  parameter int CW      = $clog2(TIMEOUT)
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic en_i,
  output logic expire_o
);

  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 2);

  logic [CW-1:0] cnt_q, cnt_d;

  // Saturates at LAST so a missed clear can never wrap into a false restart.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || !en_i) begin
      cnt_d = '0;
    end else if (cnt_q != LAST) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = en_i && !clear_i && (cnt_q == LAST);

endmodule

// File: rtl/rx_frame_ctrl.sv
// Frame parser between the serial byte receiver and the systolic array operand
// buffers: loads buffers A/B, issues compute start, reports coded errors.
module rx_frame_ctrl
  import rx_frame_pkg::*;
#(
  parameter int          MAX_LEN   = 16,
  parameter int          ADDR_W    = 4,
  parameter int          TIMEOUT   = 64,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic              rx_clk_i,
  input  logic              reset_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_in_i,
  input  logic              array_busy_i,
  output logic              wr_en_o,
  output logic              wr_sel_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [7:0]        wr_data_o,
  output logic              start_o,
  output logic              frame_ok_o,
  output logic              frame_err_o,
  output logic [2:0]        err_code_o,
  output logic              busy_o
);

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  logic [2:0]        state_q, state_d;
  logic [7:0]        cmd_q, cmd_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   idx_q, idx_d;
  logic [7:0]        csum_q, csum_d;
  logic              a_loaded_q, a_loaded_d;
  logic              b_loaded_q, b_loaded_d;
  logic              wr_en_q, wr_en_d;
  logic              wr_sel_q, wr_sel_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              start_q, start_d;
  logic              frame_ok_q, frame_ok_d;
  logic              frame_err_q, frame_err_d;
  logic [2:0]        err_code_q, err_code_d;
  logic              len_bad;
  logic              in_idle;
  logic              expire;

  assign in_idle = (state_q == ST_IDLE);

  rx_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk_i    (rx_clk_i),
    .reset_i  (reset_i),
    .clear_i  (byte_valid_i || in_idle),
    .en_i     (!in_idle),
    .expire_o (expire)
  );

  assign len_bad = is_load_cmd(cmd_q) ? ((byte_in_i == 8'd0) || (byte_in_i > MAX_LEN_B))
                                      : (byte_in_i != 8'd0);

  // A byte always takes priority over a watchdog expiry in the same cycle.
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    len_d       = len_q;
    idx_d       = idx_q;
    csum_d      = csum_q;
    a_loaded_d  = a_loaded_q;
    b_loaded_d  = b_loaded_q;
    wr_en_d     = 1'b0;
    wr_sel_d    = wr_sel_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    start_d     = 1'b0;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    err_code_d  = err_code_q;

    if (byte_valid_i) begin
      case (state_q)
        ST_IDLE: begin
          if (byte_in_i == SYNC_BYTE) begin
            state_d = ST_CMD;
            csum_d  = '0;
            idx_d   = '0;
          end
        end
        ST_CMD: begin
          cmd_d  = byte_in_i;
          csum_d = csum_q ^ byte_in_i;
          if (byte_in_i == CMD_LOAD_A) begin
            a_loaded_d = 1'b0;
            state_d    = ST_LEN;
          end else if (byte_in_i == CMD_LOAD_B) begin
            b_loaded_d = 1'b0;
            state_d    = ST_LEN;
          end else if (byte_in_i == CMD_START) begin
            state_d = ST_LEN;
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_CMD;
            state_d     = ST_IDLE;
          end
        end
        ST_LEN: begin
          csum_d = csum_q ^ byte_in_i;
          len_d  = byte_in_i[ADDR_W:0];
          idx_d  = '0;
          if (len_bad) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_LEN;
            state_d     = ST_IDLE;
          end else if (byte_in_i == 8'd0) begin
            state_d = ST_CSUM;
          end else begin
            state_d = ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          csum_d    = csum_q ^ byte_in_i;
          wr_en_d   = 1'b1;
          wr_sel_d  = (cmd_q == CMD_LOAD_B);
          wr_addr_d = idx_q[ADDR_W-1:0];
          wr_data_d = byte_in_i;
          if (idx_q == len_q - 1'b1) begin
            state_d = ST_CSUM;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        ST_CSUM: begin
          state_d = ST_IDLE;
          if (csum_q != byte_in_i) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_CSUM;
          end else if (cmd_q == CMD_LOAD_A) begin
            frame_ok_d = 1'b1;
            a_loaded_d = 1'b1;
          end else if (cmd_q == CMD_LOAD_B) begin
            frame_ok_d = 1'b1;
            b_loaded_d = 1'b1;
          end else if (a_loaded_q && b_loaded_q && !array_busy_i) begin
            frame_ok_d = 1'b1;
            start_d    = 1'b1;
            a_loaded_d = 1'b0;
            b_loaded_d = 1'b0;
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_NOT_READY;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else if (expire) begin
      frame_err_d = 1'b1;
      err_code_d  = ERR_TIMEOUT;
      state_d     = ST_IDLE;
    end
  end

  always_ff @(posedge rx_clk_i) begin
    if (!reset_i) begin
      state_q     <= ST_IDLE;
      cmd_q       <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      csum_q      <= '0;
      a_loaded_q  <= 1'b0;
      b_loaded_q  <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_sel_q    <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      start_q     <= 1'b0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      csum_q      <= csum_d;
      a_loaded_q  <= a_loaded_d;
      b_loaded_q  <= b_loaded_d;
      wr_en_q     <= wr_en_d;
      wr_sel_q    <= wr_sel_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      start_q     <= start_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
    end
  end

  assign wr_en_o     = wr_en_q;
  assign wr_sel_o    = wr_sel_q;
  assign wr_addr_o   = wr_addr_q;
  assign wr_data_o   = wr_data_q;
  assign start_o     = start_q;
  assign frame_ok_o  = frame_ok_q;
  assign frame_err_o = frame_err_q;
  assign err_code_o  = err_code_q;
  assign busy_o      = !in_idle;

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Bench for rx_frame_ctrl: directed frames plus a random byte stream, every
// cycle compared against a byte-queue reference model of the frame rules.
module tb_rx_frame_ctrl;

  localparam int MAX_LEN = 16;
  localparam int ADDR_W  = 4;
  localparam int TIMEOUT = 64;

  logic              clk = 1'b0;
  logic              resetN;
  logic              byteValid;
  logic [7:0]        byteIn;
  logic              arrayBusy;
  logic              wrEn;
  logic              wrSel;
  logic [ADDR_W-1:0] wrAddr;
  logic [7:0]        wrData;
  logic              startPulse;
  logic              frameOk;
  logic              frameErr;
  logic [2:0]        errCode;
  logic              busy;

  int checks   = 0;
  int failures = 0;

  logic       curBusy = 1'b0;
  bit         mInFrame;
  logic [7:0] mBytes[$];
  int         mIdle;
  bit         mA;
  bit         mB;
  int         mErrCode;
  bit         eWrEn, eWrSel, eOk, eErr, eStart;
  int         eWrAddr;
  int         eWrData;

  always #5 clk = ~clk;

  rx_frame_ctrl #(
    .MAX_LEN   (MAX_LEN),
    .ADDR_W    (ADDR_W),
    .TIMEOUT   (TIMEOUT),
    .SYNC_BYTE (8'hA5)
  ) dut (
    .rx_clk_i     (clk),
    .reset_i      (resetN),
    .byte_valid_i (byteValid),
    .byte_in_i    (byteIn),
    .array_busy_i (arrayBusy),
    .wr_en_o      (wrEn),
    .wr_sel_o     (wrSel),
    .wr_addr_o    (wrAddr),
    .wr_data_o    (wrData),
    .start_o      (startPulse),
    .frame_ok_o   (frameOk),
    .frame_err_o  (frameErr),
    .err_code_o   (errCode),
    .busy_o       (busy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Reference model: the frame is the byte list after SYNC; every decision is
  // made from its length and contents.
  task automatic modelEdge(input logic rstN, input logic bv, input logic [7:0] b, input logic busyIn);
    int n;
    int len;
    logic [7:0] cmd;
    logic [7:0] x;
    eWrEn = 0; eOk = 0; eErr = 0; eStart = 0;
    if (!rstN) begin
      mInFrame = 0; mBytes.delete(); mIdle = 0; mA = 0; mB = 0; mErrCode = 0;
      eWrAddr = 0; eWrData = 0; eWrSel = 0;
    end else if (bv) begin
      mIdle = 0;
      if (!mInFrame) begin
        if (b == 8'hA5) begin
          mInFrame = 1;
          mBytes.delete();
        end
      end else begin
        mBytes.push_back(b);
        n = mBytes.size();
        cmd = mBytes[0];
        if (n == 1) begin
          if (cmd == 8'h01) mA = 0;
          else if (cmd == 8'h02) mB = 0;
          else if (cmd != 8'h03) begin eErr = 1; mErrCode = 1; mInFrame = 0; end
        end else if (n == 2) begin
          if ((cmd == 8'h03) ? (b != 0) : (b == 0 || b > MAX_LEN)) begin
            eErr = 1; mErrCode = 2; mInFrame = 0;
          end
        end else begin
          len = int'(mBytes[1]);
          if (n <= len + 2) begin
            eWrEn = 1; eWrAddr = n - 3; eWrData = int'(b); eWrSel = (cmd == 8'h02);
          end else begin
            x = 8'h00;
            for (int i = 0; i < n - 1; i++) x = x ^ mBytes[i];
            mInFrame = 0;
            if (x != b) begin
              eErr = 1; mErrCode = 3;
            end else if (cmd != 8'h03) begin
              eOk = 1;
              if (cmd == 8'h01) mA = 1; else mB = 1;
            end else if (mA && mB && !busyIn) begin
              eOk = 1; eStart = 1; mA = 0; mB = 0;
            end else begin
              eErr = 1; mErrCode = 4;
            end
          end
        end
      end
    end else if (mInFrame) begin
      mIdle++;
      if (mIdle == TIMEOUT - 1) begin
        eErr = 1; mErrCode = 0; mInFrame = 0;
      end
    end
  endtask

  task automatic applyStimulus(input logic rstN, input logic bv, input logic [7:0] b, input logic busyIn);
    resetN = rstN; byteValid = bv; byteIn = b; arrayBusy = busyIn;
    @(posedge clk);
    modelEdge(rstN, bv, b, busyIn);
    #1;
    checkOutput("frame_ok", frameOk, eOk);
    checkOutput("frame_err", frameErr, eErr);
    checkOutput("start", startPulse, eStart);
    checkOutput("wr_en", wrEn, eWrEn);
    checkOutput("err_code", errCode, mErrCode);
    checkOutput("busy", busy, mInFrame);
    if (eWrEn || !rstN) begin
      checkOutput("wr_addr", wrAddr, eWrAddr);
      checkOutput("wr_data", wrData, eWrData);
      checkOutput("wr_sel", wrSel, eWrSel);
    end
  endtask

  task automatic sendByte(input logic [7:0] b);
    applyStimulus(1'b1, 1'b1, b, curBusy);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 8'h00, curBusy);
  endtask

  task automatic sendSeq(input logic [7:0] seq[$]);
    foreach (seq[i]) sendByte(seq[i]);
  endtask

  task automatic sendRandomFrame();
    logic [7:0] bytes[$];
    logic [7:0] cmd, len, x;
    int nPay, r, gap;
    r = $urandom_range(0, 99);
    cmd = (r < 38) ? 8'h01 : (r < 70) ? 8'h02 : (r < 92) ? 8'h03 : 8'($urandom);
    if (cmd == 8'h03) len = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
    else len = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(1, MAX_LEN));
    nPay = (len > 8'(MAX_LEN)) ? 3 : int'(len);
    bytes.push_back(8'hA5); bytes.push_back(cmd); bytes.push_back(len);
    x = cmd ^ len;
    for (int i = 0; i < nPay; i++) begin
      bytes.push_back(8'($urandom));
      x = x ^ bytes[bytes.size() - 1];
    end
    if ($urandom_range(0, 9) == 0) x = x ^ 8'($urandom_range(1, 255));
    bytes.push_back(x);
    curBusy = ($urandom_range(0, 4) == 0);
    foreach (bytes[i]) begin
      sendByte(bytes[i]);
      r = $urandom_range(0, 199);
      gap = (r < 150) ? 0 : (r < 194) ? $urandom_range(1, 3) : (r < 196) ? TIMEOUT - 2 :
            (r < 198) ? TIMEOUT - 1 : TIMEOUT + 6;
      idleCycles(gap);
    end
  endtask

  initial begin
    logic [7:0] s[$];
    resetN = 1'b0; byteValid = 1'b0; byteIn = 8'h00; arrayBusy = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    idleCycles(2);

    s = '{8'h00, 8'hFF};                                     sendSeq(s); idleCycles(2);
    s = '{8'hA5, 8'h01, 8'h03, 8'h11, 8'h22, 8'h33, 8'h02};  sendSeq(s); idleCycles(2);
    s = '{8'hA5, 8'h02, 8'h01, 8'h44, 8'h47};                sendSeq(s); idleCycles(2);
    s = '{8'hA5, 8'h03, 8'h00, 8'h03};                       sendSeq(s); idleCycles(2);
    sendSeq(s); idleCycles(2);
    s = '{8'hA5, 8'h02, 8'h01, 8'h44, 8'hFF};                sendSeq(s); idleCycles(2);
    s = '{8'hA5, 8'h03, 8'h00, 8'h03};                       sendSeq(s); idleCycles(2);
    s = '{8'hA5, 8'h01, 8'h11};                              sendSeq(s); idleCycles(2);
    s = '{8'hA5, 8'h07};                                     sendSeq(s); idleCycles(2);
    s = '{8'hA5, 8'h01, 8'h02};                              sendSeq(s); idleCycles(70);
    s = '{8'hA5, 8'h01, 8'h02};                              sendSeq(s); idleCycles(TIMEOUT - 2);
    s = '{8'h10, 8'h20, 8'h33};                              sendSeq(s); idleCycles(2);
    s = '{8'hA5, 8'h01, 8'h04, 8'hAA, 8'hBB};                sendSeq(s);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    idleCycles(2);
    s = '{8'hA5, 8'h02, 8'h10};                              sendSeq(s);
    for (int i = 0; i < 16; i++) sendByte(8'(i * 17));
    sendByte(8'h12);
    idleCycles(2);

    for (int iter = 0; iter < 400; iter++) begin
      case ($urandom_range(0, 19))
        0:       applyStimulus(1'b0, 1'b0, 8'h00, curBusy);
        1, 2:    sendByte(8'($urandom));
        default: sendRandomFrame();
      endcase
    end
    idleCycles(TIMEOUT + 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rx_frame_ctrl.md
Name: rx_frame_ctrl

Overview:
- Controller between the byte-level serial receiver and the systolic array operand buffers.
- Parses framed commands from the receiver's byte strobe and sequences operand loads into buffer A/B, then issues a compute start.
- Checks frame integrity, rejects malformed frames with a coded error, and aborts stalled frames via an inter-byte timeout.

Parameters:
- MAX_LEN, 16, maximum payload bytes per load frame.
- ADDR_W, 4, operand buffer address width (2**ADDR_W >= MAX_LEN).
- TIMEOUT, 64, max rx_clk cycles between bytes inside a frame.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- rx_clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- byte_valid  in  1  one-cycle strobe from receiver: byte_in holds a new byte.
- byte_in  in  8  received byte.
- array_busy  in  1  systolic array currently computing.
- wr_en  out  1  operand buffer write strobe.
- wr_sel  out  1  0 = buffer A, 1 = buffer B.
- wr_addr  out  ADDR_W  write address, payload index.
- wr_data  out  8  write data.
- start  out  1  one-cycle compute start pulse.
- frame_ok  out  1  one-cycle pulse: frame accepted.
- frame_err  out  1  one-cycle pulse: frame rejected.
- err_code  out  3  valid with frame_err; held until next frame_err.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (reset==0 at rising edge): state=IDLE; all outputs 0; a_loaded=b_loaded=0; checksum, counters cleared. Reset mid-frame discards the frame with no error pulse.
- Frame format: SYNC, CMD, LEN, LEN payload bytes, CSUM. CSUM = XOR of CMD, LEN and all payload bytes.
- CMD values: 8'h01 load A, 8'h02 load B, 8'h03 start (LEN must be 0).
- States: IDLE -> CMD -> LEN -> PAYLOAD (skipped if LEN==0) -> CSUM -> IDLE. Each transition is consumed only on a byte_valid cycle.
- IDLE:
  - Non-SYNC bytes are ignored silently.
  - SYNC moves to CMD.
  - Inside a frame, 8'hA5 is ordinary data; there is no resync.
- CMD:
  - Unknown value: frame_err, err_code=1, go to IDLE.
  - Load command: clear the matching loaded flag immediately.
- LEN:
  - Load command with LEN==0 or LEN>MAX_LEN: err_code=2.
  - Start command with LEN!=0: err_code=2.
  - Either case aborts to IDLE.
- PAYLOAD:
  - Payload byte k (0-based) gives wr_en=1, wr_addr=k, wr_data=byte, wr_sel per CMD.
  - These outputs are registered and appear exactly one cycle after its byte_valid.
  - Writes are speculative; buffer contents are valid only if the frame ends with frame_ok.
- CSUM:
  - Mismatch: frame_err, err_code=3.
  - Match on a load command: frame_ok, set the matching loaded flag.
  - Match on a start command: if a_loaded & b_loaded & !array_busy, pulse frame_ok and start in the same cycle, and clear both flags. Otherwise frame_err, err_code=4, flags unchanged.
- Latency: frame_ok, frame_err and start assert one cycle after the CSUM byte_valid. Each is a single-cycle pulse.
- Timeout:
  - Counter resets to 0 on every byte_valid and is held at 0 in IDLE.
  - If it reaches TIMEOUT-1 in any non-IDLE state without a byte: frame_err, err_code=0, go to IDLE.
  - byte_valid in the same cycle as expiry: the byte wins and the counter resets.
- Width rules:
  - Payload index is ADDR_W+1 bits internally.
  - PAYLOAD exits when index==LEN-1 is consumed.
  - wr_addr never wraps.
- err_code holds its last value between errors.
- frame_ok and frame_err are never high in the same cycle.

Decomposition:
- Shared package rx_frame_pkg holds:
  - state encoding localparams;
  - CMD constants (CMD_LOAD_A, CMD_LOAD_B, CMD_START);
  - err_code constants (ERR_TIMEOUT=0, ERR_CMD=1, ERR_LEN=2, ERR_CSUM=3, ERR_NOT_READY=4).
- One natural sub-module, rx_timeout_cnt: a loadable counter with clear on byte_valid and an expire output.
- FSM, checksum and write logic stay in rx_frame_ctrl.

Test Plan:
- Load A frame A5 01 03 11 22 33 CSUM=01^03^11^22^33=02 -> wr_en on 3 cycles with addr 0,1,2, data 11,22,33, wr_sel=0; frame_ok one cycle after CSUM; a_loaded=1.
- Load A, load B, then A5 03 00 03 with array_busy=0 -> start and frame_ok pulse together, flags cleared. Repeating the same start frame -> frame_err, err_code=4.
- Load B frame with last byte CSUM=FF (wrong) -> frame_err, err_code=3; subsequent start frame -> err_code=4.
- A5 01 11 -> frame_err, err_code=2. A5 07 -> frame_err, err_code=1. Stray bytes 00 FF before SYNC -> no pulses.
- A5 01 02 then 70 idle cycles -> frame_err, err_code=0 exactly TIMEOUT-1 cycles after the last byte. Byte arriving on the expiry cycle -> no error.
- Reset asserted mid-payload -> all outputs 0 next cycle, busy=0, no error pulse; next valid frame is accepted normally.
